// File: rtl/rosc_ctrl_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
package rosc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      START,
      GATE,
      STOP,
      READ,
      ABORT
   } state_e;

   localparam int HOLD_CYCLES_DEF  = 8;
   localparam int GATE_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF  = 2;
   localparam int STABLE_N_DEF     = 3;
   localparam int READ_TIMEOUT_DEF = 64;

   // Bits needed to hold values 0..n.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_stable_capture.sv
// Multi-flop synchronizer for an asynchronous 32-bit count plus a run counter
// that declares the value stable once STABLE_N identical samples are seen.
module sync_stable_capture
   import rosc_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int STABLE_N    = STABLE_N_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic [31:0] async_i,
   output logic [31:0] sample_o,
   output logic        stable_o
);

   localparam int FW = cnt_w(SYNC_STAGES);
   localparam int RW = cnt_w(STABLE_N);

   logic [31:0]   sync_q [SYNC_STAGES];
   logic [FW-1:0] fill_q;
   logic [RW-1:0] run_q;
   logic [31:0]   prev_q;

   // Samples only count once the chain holds data captured after clear.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         fill_q <= '0;
         run_q  <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= async_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         if (fill_q != FW'(SYNC_STAGES)) begin
            fill_q <= fill_q + FW'(1);
         end else if (run_q == '0 || sync_q[SYNC_STAGES-1] != prev_q) begin
            run_q  <= RW'(1);
            prev_q <= sync_q[SYNC_STAGES-1];
         end else if (run_q != RW'(STABLE_N)) begin
            run_q <= run_q + RW'(1);
         end
      end
   end

   assign sample_o = prev_q;
   assign stable_o = (run_q == RW'(STABLE_N));

endmodule

// File: rtl/rosc_measure_ctrl.sv
// Sequencer for one ring-oscillator timer: clear, start, gate, stop, then a
// stable cross-domain readback of the elapsed count.
module rosc_measure_ctrl
   import rosc_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
   parameter int GATE_W       = GATE_W_DEF,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int STABLE_N     = STABLE_N_DEF,
   parameter int READ_TIMEOUT = READ_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_cycles,
   output logic              busy,
   output logic              done,
   output logic [31:0]       result,
   output logic              result_valid,
   output logic              timeout_err,
   output logic              tmr_clear,
   output logic              tmr_start,
   output logic              tmr_stop,
   input  logic [31:0]       tmr_count
);

   localparam int HW = cnt_w(HOLD_CYCLES);
   localparam int TW = cnt_w(READ_TIMEOUT);

   state_e            state_q;
   logic [HW-1:0]     hold_q;
   logic [GATE_W-1:0] gate_len_q;
   logic [GATE_W-1:0] gate_cnt_q;
   logic [TW-1:0]     tmo_q;
   logic              busy_q, done_q, result_valid_q, timeout_err_q;
   logic              tmr_clear_q, tmr_start_q, tmr_stop_q;
   logic [31:0]       result_q;

   logic        cap_clear;
   logic [31:0] cap_sample;
   logic        cap_stable;

   // Capture restarts on the edge that enters READ.
   assign cap_clear = (state_q == STOP) && (hold_q == '0);

   sync_stable_capture #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_N    (STABLE_N)
   ) u_capture (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (cap_clear),
      .async_i  (tmr_count),
      .sample_o (cap_sample),
      .stable_o (cap_stable)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         hold_q         <= '0;
         gate_len_q     <= '0;
         gate_cnt_q     <= '0;
         tmo_q          <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         tmr_clear_q    <= 1'b0;
         tmr_start_q    <= 1'b0;
         tmr_stop_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort && (state_q == CLEAR || state_q == START || state_q == GATE)) begin
            // Stop the timer so it does not keep running unattended.
            state_q     <= ABORT;
            tmr_clear_q <= 1'b0;
            tmr_start_q <= 1'b0;
            tmr_stop_q  <= 1'b1;
            hold_q      <= HW'(HOLD_CYCLES - 1);
         end else begin
            case (state_q)
               IDLE: if (go) begin
                  state_q        <= CLEAR;
                  busy_q         <= 1'b1;
                  tmr_clear_q    <= 1'b1;
                  hold_q         <= HW'(HOLD_CYCLES - 1);
                  gate_len_q     <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
                  result_valid_q <= 1'b0;
                  timeout_err_q  <= 1'b0;
               end
               CLEAR: if (hold_q == '0) begin
                  state_q     <= START;
                  tmr_clear_q <= 1'b0;
                  tmr_start_q <= 1'b1;
                  hold_q      <= HW'(HOLD_CYCLES - 1);
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
               START: if (hold_q == '0) begin
                  state_q     <= GATE;
                  tmr_start_q <= 1'b0;
                  gate_cnt_q  <= gate_len_q - GATE_W'(1);
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
               GATE: if (gate_cnt_q == '0) begin
                  state_q    <= STOP;
                  tmr_stop_q <= 1'b1;
                  hold_q     <= HW'(HOLD_CYCLES - 1);
               end else begin
                  gate_cnt_q <= gate_cnt_q - GATE_W'(1);
               end
               STOP: if (hold_q == '0) begin
                  state_q    <= READ;
                  tmr_stop_q <= 1'b0;
                  tmo_q      <= TW'(READ_TIMEOUT - 1);
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
               READ: if (cap_stable) begin
                  state_q        <= IDLE;
                  busy_q         <= 1'b0;
                  done_q         <= 1'b1;
                  result_q       <= cap_sample;
                  result_valid_q <= 1'b1;
               end else if (tmo_q == '0) begin
                  state_q        <= IDLE;
                  busy_q         <= 1'b0;
                  done_q         <= 1'b1;
                  result_valid_q <= 1'b0;
                  timeout_err_q  <= 1'b1;
               end else begin
                  tmo_q <= tmo_q - TW'(1);
               end
               ABORT: if (hold_q == '0) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  tmr_stop_q <= 1'b0;
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
               default: begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  tmr_clear_q <= 1'b0;
                  tmr_start_q <= 1'b0;
                  tmr_stop_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign timeout_err  = timeout_err_q;
   assign tmr_clear    = tmr_clear_q;
   assign tmr_start    = tmr_start_q;
   assign tmr_stop     = tmr_stop_q;

endmodule

// File: tb/tb_rosc_measure_ctrl.sv
// Directed bench for rosc_measure_ctrl with a behavioural timer on a clock
// running at 2.5x the system clock period.
module tb_rosc_measure_ctrl;

   logic        clk  = 1'b0;
   logic        tclk = 1'b0;
   logic        rst, go, abort;
   logic [15:0] gate_cycles;
   logic        busy, done, result_valid, timeout_err;
   logic        tmr_clear, tmr_start, tmr_stop;
   logic [31:0] result, tmr_count;

   logic [31:0] m_cnt = '0;
   logic        m_run = 1'b0;
   logic        tog = 1'b0;
   logic        toggle_en = 1'b0;

   logic mon_en = 1'b0;
   int cyc, clr_cnt, sta_cnt, stp_cnt, done_cnt, ovl_cnt;
   int clr_first, sta_first, stp_first, done_first, busy_last;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_result;

   rosc_measure_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .go           (go),
      .abort        (abort),
      .gate_cycles  (gate_cycles),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .result_valid (result_valid),
      .timeout_err  (timeout_err),
      .tmr_clear    (tmr_clear),
      .tmr_start    (tmr_start),
      .tmr_stop     (tmr_stop),
      .tmr_count    (tmr_count)
   );

   always #2 clk = ~clk;
   initial begin
      #1;
      forever #5 tclk = ~tclk;
   end

   always @(posedge tclk) begin
      if (tmr_clear) begin
         m_cnt <= '0;
         m_run <= 1'b0;
      end else begin
         if (tmr_stop)       m_run <= 1'b0;
         else if (tmr_start) m_run <= 1'b1;
         if (m_run) m_cnt <= m_cnt + 32'd1;
      end
   end

   always @(negedge clk) tog <= ~tog;
   assign tmr_count = toggle_en ? {31'b0, tog} : m_cnt;

   always @(negedge clk) begin
      if (!mon_en) begin
         cyc <= 0; clr_cnt <= 0; sta_cnt <= 0; stp_cnt <= 0; done_cnt <= 0; ovl_cnt <= 0;
         clr_first <= 0; sta_first <= 0; stp_first <= 0; done_first <= 0; busy_last <= 0;
      end else begin
         cyc <= cyc + 1;
         if (tmr_clear) begin clr_cnt <= clr_cnt + 1; if (clr_first == 0) clr_first <= cyc + 1; end
         if (tmr_start) begin sta_cnt <= sta_cnt + 1; if (sta_first == 0) sta_first <= cyc + 1; end
         if (tmr_stop)  begin stp_cnt <= stp_cnt + 1; if (stp_first == 0) stp_first <= cyc + 1; end
         if (done)      begin done_cnt <= done_cnt + 1; if (done_first == 0) done_first <= cyc + 1; end
         if (busy) busy_last <= cyc + 1;
         if ((int'(tmr_clear) + int'(tmr_start) + int'(tmr_stop)) > 1) ovl_cnt <= ovl_cnt + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
      $fatal(1);
   end

   // Issues go so that the DUT samples it at edge E0; monitor cycle 1 is the
   // negedge right after E0.
   task automatic go_meas(input int g);
      mon_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      gate_cycles = 16'(g);
      go          = 1'b1;
      mon_en      = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 1'b0; abort = 1'b0; gate_cycles = '0;
      repeat (3) @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", result); end
      n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", result_valid); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
      n_tests++; if ({tmr_clear, tmr_start, tmr_stop} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000", {tmr_clear, tmr_start, tmr_stop}); end
      #1 rst = 1'b0;
   endtask

   task automatic test_basic();
      bit to;
      go_meas(100);
      wait_idle(400, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL basic_idle: busy still %b after budget, want 0", busy); end
      n_tests++; if (clr_cnt != 8 || clr_first != 1) begin n_fail++; $display("FAIL basic_clear: got %0d cycles from %0d want 8 from 1", clr_cnt, clr_first); end
      n_tests++; if (sta_cnt != 8 || sta_first != 9) begin n_fail++; $display("FAIL basic_start: got %0d cycles from %0d want 8 from 9", sta_cnt, sta_first); end
      n_tests++; if (stp_cnt != 8 || stp_first != 117) begin n_fail++; $display("FAIL basic_stop: got %0d cycles from %0d want 8 from 117", stp_cnt, stp_first); end
      n_tests++; if (ovl_cnt != 0) begin n_fail++; $display("FAIL basic_overlap: got %0d want 0", ovl_cnt); end
      n_tests++; if (done_cnt != 1 || done_first < 130 || done_first > 134) begin n_fail++; $display("FAIL basic_done: got %0d pulses at %0d want 1 in 130..134", done_cnt, done_first); end
      n_tests++; if (result !== m_cnt) begin n_fail++; $display("FAIL basic_result: got %0d want %0d", result, m_cnt); end
      n_tests++; if (result_valid !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got valid=%b tmo=%b want 1 0", result_valid, timeout_err); end
   endtask

   task automatic test_gate_zero();
      bit to;
      go_meas(0);
      wait_idle(200, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL gate0_idle: busy still %b after budget, want 0", busy); end
      n_tests++; if (stp_first != 18) begin n_fail++; $display("FAIL gate0_len: stop at %0d want 18", stp_first); end
      n_tests++; if (done_cnt != 1 || result !== m_cnt || result_valid !== 1'b1) begin n_fail++; $display("FAIL gate0_result: got done=%0d result=%0d valid=%b want 1 %0d 1", done_cnt, result, result_valid, m_cnt); end
   endtask

   task automatic test_go_during_gate();
      bit to;
      go_meas(40);
      repeat (30) @(negedge clk);
      #1 go = 1'b1;
      @(negedge clk);
      #1 go = 1'b0;
      wait_idle(300, to);
      repeat (20) @(negedge clk);
      #1;
      n_tests++; if (to) begin n_fail++; $display("FAIL regate_idle: busy still %b after budget, want 0", busy); end
      n_tests++; if (clr_cnt != 8 || sta_cnt != 8) begin n_fail++; $display("FAIL regate_ctrl: got clear=%0d start=%0d want 8 8", clr_cnt, sta_cnt); end
      n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL regate_done: got %0d want 1", done_cnt); end
      n_tests++; if (result !== m_cnt) begin n_fail++; $display("FAIL regate_result: got %0d want %0d", result, m_cnt); end
      last_result = m_cnt;
   endtask

   task automatic test_abort();
      bit to;
      go_meas(100);
      repeat (26) @(negedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      #1 abort = 1'b0;
      wait_idle(100, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL abort_idle: busy still %b after budget, want 0", busy); end
      n_tests++; if (stp_cnt != 8 || stp_first != 27) begin n_fail++; $display("FAIL abort_stop: got %0d cycles from %0d want 8 from 27", stp_cnt, stp_first); end
      n_tests++; if (busy_last != 34) begin n_fail++; $display("FAIL abort_busy: last busy cycle %0d want 34", busy_last); end
      n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
      n_tests++; if (result_valid !== 1'b0 || result !== last_result) begin n_fail++; $display("FAIL abort_result: got valid=%b result=%0d want 0 %0d", result_valid, result, last_result); end
   endtask

   task automatic test_timeout();
      bit to;
      toggle_en = 1'b1;
      go_meas(10);
      wait_idle(300, to);
      toggle_en = 1'b0;
      n_tests++; if (to) begin n_fail++; $display("FAIL tmo_idle: busy still %b after budget, want 0", busy); end
      n_tests++; if (done_cnt != 1 || done_first != 99) begin n_fail++; $display("FAIL tmo_done: got %0d pulses at %0d want 1 at 99", done_cnt, done_first); end
      n_tests++; if (timeout_err !== 1'b1 || result_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_flags: got tmo=%b valid=%b want 1 0", timeout_err, result_valid); end
      n_tests++; if (result !== last_result) begin n_fail++; $display("FAIL tmo_result: got %0d want %0d", result, last_result); end
   endtask

   task automatic test_reset_mid();
      bit to;
      go_meas(20);
      repeat (12) @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if ({busy, done, result_valid, timeout_err, tmr_clear, tmr_start, tmr_stop} !== 7'b0 || result !== 32'd0) begin
         n_fail++; $display("FAIL rstmid_outs: got flags=%b result=%0d want 0 0", {busy, done, result_valid, timeout_err, tmr_clear, tmr_start, tmr_stop}, result);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      n_tests++; if (done_cnt != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got done=%0d busy=%b want 0 0", done_cnt, busy); end
      go_meas(20);
      wait_idle(200, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL rstmid_idle: busy still %b after budget, want 0", busy); end
      n_tests++; if (clr_cnt != 8 || sta_cnt != 8 || stp_cnt != 8 || stp_first != 37) begin n_fail++; $display("FAIL rstmid_ctrl: got %0d %0d %0d stop@%0d want 8 8 8 stop@37", clr_cnt, sta_cnt, stp_cnt, stp_first); end
      n_tests++; if (done_cnt != 1 || result !== m_cnt || result_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_result: got done=%0d result=%0d valid=%b want 1 %0d 1", done_cnt, result, result_valid, m_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gate_zero();
      test_go_during_gate();
      test_abort();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
